// File: rtl/termbuffer_grid_if.sv
// Byte-stream bundle of the terminal screen buffer: RX bytes in, screen dump out,
// plus busy status and the committed cursor position.
interface termbuffer_grid_if #(
  parameter int COLS = 80,
  parameter int ROWS = 24
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic [7:0]    i_serial;
  logic          i_serial_v;
  logic          i_serial_ready;
  logic          i_dump;
  logic [7:0]    o_serial;
  logic          o_serial_v;
  logic          o_serial_ready;
  logic          o_busy;
  logic [CW-1:0] o_col;
  logic [RW-1:0] o_row;

  // Screen-buffer side
  modport slave (
    input  i_serial, i_serial_v, i_dump, o_serial_ready,
    output i_serial_ready, o_serial, o_serial_v, o_busy, o_col, o_row
  );

  // Environment side: drives RX bytes and dump requests, throttles the dump stream
  modport master (
    output i_serial, i_serial_v, i_dump, o_serial_ready,
    input  i_serial_ready, o_serial, o_serial_v, o_busy, o_col, o_row
  );
endinterface

// File: rtl/termbuffer_grid.sv
// ROWS x COLS terminal screen buffer: interprets printable/CR/LF/BS bytes, scrolls
// at the bottom row and streams the whole screen out behind an ESC [ H prefix.
module termbuffer_grid #(
  parameter int COLS      = 80,
  parameter int ROWS      = 24,
  parameter bit AUTO_DUMP = 1'b1
) (
  input logic              clk,
  input logic              rst,
  termbuffer_grid_if.slave bus
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);
  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);

  localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);
  localparam logic [AW-1:0] COPY_END  = AW'(CELLS - COLS);
  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_ESC   = 8'h1B;
  localparam logic [7:0] CH_LBRK  = 8'h5B;
  localparam logic [7:0] CH_H     = 8'h48;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_BS    = 8'h08;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_SCROLL,
    S_DUMP
  } state_e;

  // What the dump stream loads into the output register on the next transfer
  typedef enum logic [2:0] {
    N_HDR1,
    N_HDR2,
    N_CELL,
    N_CR,
    N_LF,
    N_END
  } nxt_e;

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          pend_q, pend_d;
  logic [7:0]    out_q, out_d;
  logic          out_v_q, out_v_d;
  nxt_e          nxt_q, nxt_d;
  logic [AW-1:0] cell_q, cell_d;
  logic [CW-1:0] dcol_q, dcol_d;
  logic [RW-1:0] drow_q, drow_d;

  logic [7:0]    mem [CELLS];
  logic [7:0]    rd_data_q;
  logic          we;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [AW-1:0] rd_addr;

  logic [AW-1:0] cursor_addr;
  logic          adv_row;
  logic          start_dump;

  assign cursor_addr = AW'(int'(row_q) * COLS + int'(col_q));

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    pend_d     = pend_q | bus.i_dump;
    out_d      = out_q;
    out_v_d    = out_v_q;
    nxt_d      = nxt_q;
    cell_d     = cell_q;
    dcol_d     = dcol_q;
    drow_d     = drow_q;
    we         = 1'b0;
    wr_addr    = cursor_addr;
    wr_data    = bus.i_serial;
    rd_addr    = '0;
    adv_row    = 1'b0;
    start_dump = 1'b0;

    unique case (state_q)
      S_CLEAR: begin
        we      = 1'b1;
        wr_addr = cnt_q;
        wr_data = CH_SPACE;
        if (cnt_q == LAST_CELL) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_IDLE: begin
        if (bus.i_serial_v) begin
          if (AUTO_DUMP) pend_d = 1'b1;
          if (bus.i_serial inside {[8'h20:8'h7E]}) begin
            we = 1'b1;
            if (col_q == LAST_COL) begin
              col_d   = '0;
              adv_row = 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else if (bus.i_serial == CH_CR) begin
            col_d = '0;
          end else if (bus.i_serial == CH_LF) begin
            adv_row = 1'b1;
          end else if (bus.i_serial == CH_BS) begin
            if (col_q != '0) col_d = col_q - 1'b1;
          end
        end

        if (adv_row) begin
          if (row_q == LAST_ROW) begin
            state_d = S_SCROLL;
            cnt_d   = '0;
            phase_d = 1'b0;
          end else begin
            row_d = row_q + 1'b1;
          end
        end

        // A scroll owed by this byte runs before any pending dump
        if (!(adv_row && row_q == LAST_ROW) && pend_q) start_dump = 1'b1;
      end

      S_SCROLL: begin
        if (cnt_q < COPY_END) begin
          if (!phase_q) begin
            rd_addr = cnt_q + AW'(COLS);
            phase_d = 1'b1;
          end else begin
            we      = 1'b1;
            wr_addr = cnt_q;
            wr_data = rd_data_q;
            phase_d = 1'b0;
            cnt_d   = cnt_q + 1'b1;
          end
        end else begin
          we      = 1'b1;
          wr_addr = cnt_q;
          wr_data = CH_SPACE;
          if (cnt_q == LAST_CELL) begin
            cnt_d = '0;
            if (pend_q) start_dump = 1'b1;
            else        state_d    = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_DUMP: begin
        if (out_v_q && bus.o_serial_ready) begin
          unique case (nxt_q)
            N_HDR1: begin
              out_d = CH_LBRK;
              nxt_d = N_HDR2;
            end
            N_HDR2: begin
              out_d = CH_H;
              nxt_d = N_CELL;
            end
            N_CELL: begin
              out_d  = rd_data_q;
              cell_d = cell_q + 1'b1;
              if (dcol_q == LAST_COL) begin
                dcol_d = '0;
                nxt_d  = (drow_q == LAST_ROW) ? N_END : N_CR;
              end else begin
                dcol_d = dcol_q + 1'b1;
              end
            end
            N_CR: begin
              out_d = CH_CR;
              nxt_d = N_LF;
            end
            N_LF: begin
              out_d  = CH_LF;
              drow_d = drow_q + 1'b1;
              nxt_d  = N_CELL;
            end
            default: begin
              out_d   = '0;
              out_v_d = 1'b0;
              state_d = S_IDLE;
            end
          endcase
        end
      end

      default: state_d = S_CLEAR;
    endcase

    if (start_dump) begin
      state_d = S_DUMP;
      pend_d  = 1'b0;
      out_d   = CH_ESC;
      out_v_d = 1'b1;
      nxt_d   = N_HDR1;
      cell_d  = '0;
      dcol_d  = '0;
      drow_d  = '0;
    end

    // Prefetch: the read register always holds the next cell the stream will load
    if (state_d == S_DUMP) rd_addr = cell_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_CLEAR;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      pend_q  <= 1'b0;
      out_q   <= '0;
      out_v_q <= 1'b0;
      nxt_q   <= N_HDR1;
      cell_q  <= '0;
      dcol_q  <= '0;
      drow_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
      out_v_q <= out_v_d;
      nxt_q   <= nxt_d;
      cell_q  <= cell_d;
      dcol_q  <= dcol_d;
      drow_q  <= drow_d;
    end
  end

  // NOTE: the grid RAM and its read register have no reset; CLEAR initialises every cell.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data_q <= mem[rd_addr];
  end

  assign bus.i_serial_ready = (state_q == S_IDLE);
  assign bus.o_busy         = (state_q != S_IDLE);
  assign bus.o_serial       = out_q;
  assign bus.o_serial_v     = out_v_q;
  assign bus.o_col          = col_q;
  assign bus.o_row          = row_q;

endmodule
